traffic_gen: RTL and testbench

Parametrised packet-level traffic source for the 2D NoC, replacing the single-flit fixed-destination source. Emits multi-flit packets (head/body/tail) toward a fixed, round-robin or pseudo-random destination. Packets are separated by a programmable idle gap and capped by an optional packet budget. Drives the `tx` serialiser through the existing one-cycle `req` / `busy` handshake.

---
 rtl/traffic_gen.sv | 184 ++++++++++++++++++
 tb/tb_traffic_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_gen.sv
// traffic_gen: multi-flit NoC packet source (fixed / round-robin / LFSR destination,
// idle gap, packet budget). Define TRAFFIC_GEN_LOG_EN for per-flit simulation logging.
`ifndef NUM_NODES
`define NUM_NODES 4
`endif
`ifndef SIZE
`define SIZE 16
`endif

module traffic_gen #(
    parameter int unsigned ID        = 0,
    parameter int unsigned DEST_MODE = 0,
    parameter int unsigned DEST      = `NUM_NODES - 1,
    parameter int unsigned PKT_LEN   = 4,
    parameter int unsigned MAX_PKTS  = 0,
    parameter int unsigned GAP       = 0,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             busy,
    output logic             req,
    output logic [`SIZE-1:0] data,
    output logic             done,
    output logic [15:0]      pkt_cnt
);
    localparam int unsigned   NN        = `NUM_NODES;
    localparam int unsigned   SW        = `SIZE;
    localparam int unsigned   PW        = SW - 2;
    localparam int unsigned   DW        = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [15:0]   SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [DW-1:0] RR_INIT   = DW'((ID + 1) % NN);
    localparam logic [7:0]    LAST_IDX  = 8'(PKT_LEN - 1);
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;
    localparam bit            BUDGET_EN = (MAX_PKTS != 0);

    typedef enum logic [1:0] {S_SEND, S_GAP, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_gap_cnt, w_gap_nxt;
    logic [15:0]   r_lfsr, w_lfsr_nxt;
    logic [DW-1:0] r_rr_ptr, w_rr_nxt;
    logic [15:0]   r_seq, w_seq_nxt;
    logic          r_req, w_req_nxt;
    logic [SW-1:0] r_data, w_data_nxt;
    logic          r_done, w_done_nxt;
    logic [15:0]   r_pkt_cnt, w_pkt_cnt_nxt;

    logic          w_is_head;
    logic          w_is_tail;
    logic [1:0]    w_type;
    logic [DW-1:0] w_head_dest;
    logic [PW-1:0] w_payload;
    logic [15:0]   w_lfsr_shift;
    logic [15:0]   w_cnt_inc;

    // Reduce to a node index, stepping past our own ID when it would be hit.
    function automatic logic [DW-1:0] wrap_skip(input logic [31:0] v);
        logic [31:0] m;
        m = v % NN;
        if (m == ID) m = (m + 32'd1) % NN;
        return DW'(m);
    endfunction

    assign w_is_head    = (r_idx == 8'd0);
    assign w_is_tail    = (r_idx == LAST_IDX);
    assign w_type       = {w_is_tail, w_is_head};
    assign w_lfsr_shift = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    assign w_cnt_inc    = (r_pkt_cnt == 16'hFFFF) ? r_pkt_cnt : r_pkt_cnt + 16'd1;

    always_comb begin
        case (DEST_MODE)
            0:       w_head_dest = DW'(DEST);
            1:       w_head_dest = r_rr_ptr;
            default: w_head_dest = wrap_skip({16'h0000, r_lfsr});
        endcase
    end

    assign w_payload = w_is_head ? PW'(w_head_dest) : PW'(r_seq);

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_gap_nxt     = r_gap_cnt;
        w_lfsr_nxt    = r_lfsr;
        w_rr_nxt      = r_rr_ptr;
        w_seq_nxt     = r_seq;
        w_req_nxt     = 1'b0;
        w_data_nxt    = r_data;
        w_done_nxt    = r_done;
        w_pkt_cnt_nxt = r_pkt_cnt;
        unique case (r_state)
            S_SEND: begin
                // A stalled cycle leaves index, seq and destination state untouched.
                if (!busy) begin
                    w_req_nxt  = 1'b1;
                    w_data_nxt = {w_type, w_payload};
                    if (w_is_head) begin
                        if (DEST_MODE == 1) w_rr_nxt = wrap_skip(32'(r_rr_ptr) + 32'd1);
                        if (DEST_MODE >= 2) w_lfsr_nxt = w_lfsr_shift;
                    end else begin
                        w_seq_nxt = r_seq + 16'd1;
                    end
                    if (w_is_tail) begin
                        w_idx_nxt     = '0;
                        w_pkt_cnt_nxt = w_cnt_inc;
                        if (BUDGET_EN && (32'(w_cnt_inc) == MAX_PKTS)) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else if (GAP != 0) begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = 8'(GAP);
                        end
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end
            end
            S_GAP: begin
                w_gap_nxt = r_gap_cnt - 8'd1;
                if (r_gap_cnt <= 8'd1) w_state_nxt = S_SEND;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_SEND;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_SEND;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_lfsr    <= SEED_EFF;
            r_rr_ptr  <= RR_INIT;
            r_seq     <= '0;
            r_req     <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_idx     <= w_idx_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_seq     <= w_seq_nxt;
            r_req     <= w_req_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_pkt_cnt <= w_pkt_cnt_nxt;
        end
    end

    assign req     = r_req;
    assign data    = r_data;
    assign done    = r_done;
    assign pkt_cnt = r_pkt_cnt;

`ifdef TRAFFIC_GEN_LOG_EN
    logic [DW-1:0] r_log_dest;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       r_log_dest <= '0;
        else if (r_state == S_SEND && !busy && w_is_head) r_log_dest <= w_head_dest;
    end

    always_ff @(posedge clk) begin
        if (!reset && r_state == S_SEND && !busy)
            $display("[%0t] traffic_gen %0d: pkt %0d flit %0d type %b dest %0d", $time, ID,
                     r_pkt_cnt, r_idx, w_type, w_is_head ? w_head_dest : r_log_dest);
        if (!reset && r_state != S_DONE && w_state_nxt == S_DONE)
            $display("[%0t] traffic_gen %0d: done after %0d packets", $time, ID, w_cnt_inc);
    end
`endif

endmodule

// File: tb/tb_traffic_gen.sv
// Self-checking bench for traffic_gen: four differently parameterised instances checked
// against a packet-level reference model, with randomized busy back-pressure.
`ifndef NUM_NODES
`define NUM_NODES 4
`endif
`ifndef SIZE
`define SIZE 16
`endif

module tb_traffic_gen;
    localparam int NN = `NUM_NODES;
    localparam int SW = `SIZE;
    localparam int PW = SW - 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          busy [4];
    logic          req  [4];
    logic [SW-1:0] data [4];
    logic          done [4];
    logic [15:0]   cnt  [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traffic_gen #(.ID(0), .DEST_MODE(0), .DEST(3), .PKT_LEN(3), .MAX_PKTS(0), .GAP(0)) u_fixed (
        .clk(clk), .reset(reset), .busy(busy[0]), .req(req[0]), .data(data[0]),
        .done(done[0]), .pkt_cnt(cnt[0]));
    traffic_gen #(.ID(0), .DEST_MODE(0), .DEST(1), .PKT_LEN(2), .MAX_PKTS(2), .GAP(0)) u_budget (
        .clk(clk), .reset(reset), .busy(busy[1]), .req(req[1]), .data(data[1]),
        .done(done[1]), .pkt_cnt(cnt[1]));
    traffic_gen #(.ID(2), .DEST_MODE(1), .PKT_LEN(1), .MAX_PKTS(0), .GAP(3)) u_gaprr (
        .clk(clk), .reset(reset), .busy(busy[2]), .req(req[2]), .data(data[2]),
        .done(done[2]), .pkt_cnt(cnt[2]));
    traffic_gen #(.ID(1), .DEST_MODE(2), .PKT_LEN(4), .MAX_PKTS(0), .GAP(2)) u_rand (
        .clk(clk), .reset(reset), .busy(busy[3]), .req(req[3]), .data(data[3]),
        .done(done[3]), .pkt_cnt(cnt[3]));

    // Expected flit from the packet number and flit position within the packet.
    function automatic logic [SW-1:0] model_flit(input int mode, input int id, input int dest,
                                                 input int len, input int pkt, input int flit);
        int            d;
        int            s;
        logic [15:0]   v;
        logic [1:0]    t;
        logic [PW-1:0] pl;
        if (mode == 0) begin
            d = dest;
        end else if (mode == 1) begin
            d = (id + 1 + (pkt % (NN - 1))) % NN;
        end else begin
            v = 16'hACE1;
            for (int i = 0; i < pkt; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
            d = int'(v) % NN;
            if (d == id) d = (d + 1) % NN;
        end
        t = {(flit == len - 1), (flit == 0)};
        if (flit == 0) begin
            pl = PW'(d);
        end else begin
            s  = (pkt * (len - 1) + flit - 1) % 65536;
            pl = PW'(s);
        end
        return {t, pl};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) busy[i] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (req[i] !== 1'b0) begin n_err++; $display("FAIL reset_req[%0d]: got %b want 0", i, req[i]); end
            n_vec++;
            if (data[i] !== '0) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 0", i, data[i]); end
            n_vec++;
            if (done[i] !== 1'b0) begin n_err++; $display("FAIL reset_done[%0d]: got %b want 0", i, done[i]); end
            n_vec++;
            if (cnt[i] !== 16'd0) begin n_err++; $display("FAIL reset_cnt[%0d]: got %0d want 0", i, cnt[i]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_fixed_seq();
        logic [SW-1:0] exp_d;
        do_reset();
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); @(negedge clk);
            exp_d = model_flit(0, 0, 3, 3, (e - 1) / 3, (e - 1) % 3);
            n_vec++;
            if (req[0] !== 1'b1) begin n_err++; $display("FAIL fixed_req e=%0d: got %b want 1", e, req[0]); end
            n_vec++;
            if (data[0] !== exp_d) begin n_err++; $display("FAIL fixed_data e=%0d: got %h want %h", e, data[0], exp_d); end
            n_vec++;
            if (cnt[0] !== 16'(e / 3)) begin n_err++; $display("FAIL fixed_cnt e=%0d: got %0d want %0d", e, cnt[0], e / 3); end
        end
    endtask

    task automatic test_busy_stall();
        int            k = 0;
        logic          b;
        logic [SW-1:0] exp_d = '0;
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            b = (e >= 2 && e <= 6);
            busy[0] = b;
            @(posedge clk); @(negedge clk);
            if (!b) begin
                exp_d = model_flit(0, 0, 3, 3, k / 3, k % 3);
                k++;
            end
            n_vec++;
            if (req[0] !== !b) begin n_err++; $display("FAIL stall_req e=%0d: got %b want %b", e, req[0], !b); end
            n_vec++;
            if (data[0] !== exp_d) begin n_err++; $display("FAIL stall_data e=%0d: got %h want %h", e, data[0], exp_d); end
        end
        busy[0] = 1'b0;
    endtask

    task automatic test_budget();
        int            pkt = 0, flit = 0, pulses = 0, hit_e = 0;
        logic          b, exp_req;
        logic [SW-1:0] exp_d = '0;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            b = ($urandom_range(0, 2) == 0);
            busy[1] = b;
            @(posedge clk); @(negedge clk);
            exp_req = !b && (pkt < 2);
            if (exp_req) begin
                exp_d = model_flit(0, 0, 1, 2, pkt, flit);
                flit++;
                if (flit == 2) begin
                    flit = 0;
                    pkt++;
                    if (pkt == 2) hit_e = e;
                end
            end
            if (req[1] === 1'b1) pulses++;
            n_vec++;
            if (req[1] !== exp_req) begin n_err++; $display("FAIL budget_req e=%0d: got %b want %b", e, req[1], exp_req); end
            n_vec++;
            if (data[1] !== exp_d) begin n_err++; $display("FAIL budget_data e=%0d: got %h want %h", e, data[1], exp_d); end
            n_vec++;
            if (cnt[1] !== 16'(pkt)) begin n_err++; $display("FAIL budget_cnt e=%0d: got %0d want %0d", e, cnt[1], pkt); end
            if (hit_e == 0 || e > hit_e) begin
                n_vec++;
                if (done[1] !== (hit_e != 0)) begin
                    n_err++; $display("FAIL budget_done e=%0d: got %b want %b", e, done[1], hit_e != 0);
                end
            end
        end
        n_vec++;
        if (pulses != 4) begin n_err++; $display("FAIL budget_pulses: got %0d want 4", pulses); end
        busy[1] = 1'b0;
    endtask

    task automatic test_gap_rr();
        logic          exp_req;
        logic [SW-1:0] exp_d = '0;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); @(negedge clk);
            exp_req = ((e - 1) % 4 == 0);
            if (exp_req) exp_d = model_flit(1, 2, 0, 1, (e - 1) / 4, 0);
            n_vec++;
            if (req[2] !== exp_req) begin n_err++; $display("FAIL gap_req e=%0d: got %b want %b", e, req[2], exp_req); end
            n_vec++;
            if (data[2] !== exp_d) begin n_err++; $display("FAIL gap_data e=%0d: got %h want %h", e, data[2], exp_d); end
            n_vec++;
            if (cnt[2] !== 16'((e - 1) / 4 + 1)) begin
                n_err++; $display("FAIL gap_cnt e=%0d: got %0d want %0d", e, cnt[2], (e - 1) / 4 + 1);
            end
        end
    endtask

    task automatic test_random_traffic();
        int            pkt = 0, flit = 0, next_ok = 1;
        logic          b, exp_req;
        logic [SW-1:0] exp_d = '0;
        do_reset();
        for (int e = 1; e <= 400; e++) begin
            b = ($urandom_range(0, 3) == 0);
            busy[3] = b;
            @(posedge clk); @(negedge clk);
            exp_req = !b && (e >= next_ok);
            if (exp_req) begin
                exp_d = model_flit(2, 1, 0, 4, pkt, flit);
                flit++;
                if (flit == 4) begin
                    flit    = 0;
                    pkt++;
                    next_ok = e + 2 + 1;
                end
            end
            n_vec++;
            if (req[3] !== exp_req) begin n_err++; $display("FAIL rand_req e=%0d: got %b want %b", e, req[3], exp_req); end
            n_vec++;
            if (data[3] !== exp_d) begin n_err++; $display("FAIL rand_data e=%0d: got %h want %h", e, data[3], exp_d); end
            n_vec++;
            if (cnt[3] !== 16'(pkt)) begin n_err++; $display("FAIL rand_cnt e=%0d: got %0d want %0d", e, cnt[3], pkt); end
        end
        busy[3] = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        logic [SW-1:0] exp_d;
        do_reset();
        repeat (8) begin @(posedge clk); @(negedge clk); end
        exp_d = model_flit(2, 1, 0, 4, 1, 1);
        n_vec++;
        if (req[3] !== 1'b1 || data[3] !== exp_d) begin
            n_err++; $display("FAIL midrst_pre: got req=%b data=%h want req=1 data=%h", req[3], data[3], exp_d);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (req[3] !== 1'b0) begin n_err++; $display("FAIL midrst_req: got %b want 0", req[3]); end
        n_vec++;
        if (data[3] !== '0) begin n_err++; $display("FAIL midrst_data: got %h want 0", data[3]); end
        n_vec++;
        if (cnt[3] !== 16'd0) begin n_err++; $display("FAIL midrst_cnt: got %0d want 0", cnt[3]); end
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); @(negedge clk);
            exp_d = model_flit(2, 1, 0, 4, 0, e - 1);
            n_vec++;
            if (req[3] !== 1'b1 || data[3] !== exp_d) begin
                n_err++; $display("FAIL midrst_post e=%0d: got req=%b data=%h want req=1 data=%h", e, req[3], data[3], exp_d);
            end
        end
        n_vec++;
        if (cnt[3] !== 16'd1) begin n_err++; $display("FAIL midrst_cnt_post: got %0d want 1", cnt[3]); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) busy[i] = 1'b0;
        test_reset();
        test_fixed_seq();
        test_busy_stall();
        test_budget();
        test_gap_rr();
        test_random_traffic();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
